// File: rtl/complex_round_saturate.sv
// complex_round_saturate: output formatting stage after the complex multiplier.
// Round (arithmetic right shift by FRAC_SHIFT) then saturate real/imag products
// to DATA_WIDTH bits through a two-register valid/ready pipeline, with sticky
// saturation flags and a non-wrapping saturation event counter.
// Build option: define ROUND_EVEN_EN for convergent (round-half-to-even) rounding;
// left undefined the stage rounds half-up toward +inf.
module complex_round_saturate #(
  parameter int DATA_WIDTH = 16,
  parameter int FRAC_SHIFT = 15,
  parameter int CNT_WIDTH  = 16
) (
  input  logic                         i_clk,
  input  logic                         i_rst,
  input  logic signed [2*DATA_WIDTH:0] i_real,
  input  logic signed [2*DATA_WIDTH:0] i_imag,
  input  logic                         i_valid,
  output logic                         o_ready,
  output logic signed [DATA_WIDTH-1:0] o_real,
  output logic signed [DATA_WIDTH-1:0] o_imag,
  output logic                         o_valid,
  input  logic                         i_ready,
  output logic                         o_sat_real,
  output logic                         o_sat_imag,
  output logic [CNT_WIDTH-1:0]         o_sat_count,
  input  logic                         i_clear_sat
);

  localparam int IN_W = 2 * DATA_WIDTH + 1;
  // One guard bit so the rounding add can never overflow.
  localparam int R_W  = IN_W + 1;
  localparam logic signed [R_W-1:0] ROUND_CONST = R_W'(1'b1) << (FRAC_SHIFT - 1);
`ifdef ROUND_EVEN_EN
  localparam logic [FRAC_SHIFT-1:0] HALF_LSB = FRAC_SHIFT'(1'b1) << (FRAC_SHIFT - 1);
`endif

  // Round-half-up shift; the convergent build pulls exact ties back to even.
  function automatic logic signed [R_W-1:0] round_shift(input logic signed [IN_W-1:0] x);
    logic signed [R_W-1:0] sum;
    logic signed [R_W-1:0] res;
    sum = $signed({x[IN_W-1], x}) + ROUND_CONST;
    res = sum >>> FRAC_SHIFT;
`ifdef ROUND_EVEN_EN
    // A tie rounded up to an odd value came from an even floor: step back.
    if ((x[FRAC_SHIFT-1:0] == HALF_LSB) && res[0]) begin
      res = res - R_W'(1'b1);
    end
`endif
    return res;
  endfunction

  // Clamp to DATA_WIDTH signed; returns {saturated_flag, value}.
  function automatic logic [DATA_WIDTH:0] saturate(input logic signed [R_W-1:0] r);
    logic [DATA_WIDTH:0] res;
    if (r[R_W-1:DATA_WIDTH-1] == {(R_W-DATA_WIDTH+1){r[R_W-1]}}) begin
      res = {1'b0, r[DATA_WIDTH-1:0]};
    end else if (r[R_W-1]) begin
      res = {1'b1, 1'b1, {(DATA_WIDTH-1){1'b0}}};
    end else begin
      res = {1'b1, 1'b0, {(DATA_WIDTH-1){1'b1}}};
    end
    return res;
  endfunction

  logic                  s1_valid;
  logic signed [R_W-1:0] r_real;
  logic signed [R_W-1:0] r_imag;
  logic                  load1;
  logic                  load2;
  logic [DATA_WIDTH:0]   sat_real_res;
  logic [DATA_WIDTH:0]   sat_imag_res;
  logic                  det_real;
  logic                  det_imag;

  // Handshake: each stage loads when it is empty or its contents move on.
  assign load2   = !o_valid | i_ready;
  assign load1   = !s1_valid | load2;
  assign o_ready = load1;

  // Saturation decode of the S1 contents and detection qualified by an S2 load.
  always_comb begin
    sat_real_res = saturate(r_real);
    sat_imag_res = saturate(r_imag);
    det_real     = load2 & s1_valid & sat_real_res[DATA_WIDTH];
    det_imag     = load2 & s1_valid & sat_imag_res[DATA_WIDTH];
  end

  // S1: rounded products; data only captured for valid input samples.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      s1_valid <= 1'b0;
      r_real   <= '0;
      r_imag   <= '0;
    end else if (load1) begin
      s1_valid <= i_valid;
      if (i_valid) begin
        r_real <= round_shift(i_real);
        r_imag <= round_shift(i_imag);
      end
    end
  end

  // S2: saturated output register, held while downstream stalls.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_valid <= 1'b0;
      o_real  <= '0;
      o_imag  <= '0;
    end else if (load2) begin
      o_valid <= s1_valid;
      if (s1_valid) begin
        o_real <= sat_real_res[DATA_WIDTH-1:0];
        o_imag <= sat_imag_res[DATA_WIDTH-1:0];
      end
    end
  end

  // Sticky flags and saturating event counter; clear beats a same-cycle event.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      o_sat_real  <= 1'b0;
      o_sat_imag  <= 1'b0;
      o_sat_count <= '0;
    end else if (i_clear_sat) begin
      o_sat_real  <= 1'b0;
      o_sat_imag  <= 1'b0;
      o_sat_count <= '0;
    end else begin
      if (det_real) begin
        o_sat_real <= 1'b1;
      end
      if (det_imag) begin
        o_sat_imag <= 1'b1;
      end
      if ((det_real | det_imag) && (o_sat_count != {CNT_WIDTH{1'b1}})) begin
        o_sat_count <= o_sat_count + CNT_WIDTH'(1'b1);
      end
    end
  end

endmodule

// File: tb/tb_complex_round_saturate.sv
// Self-checking bench for complex_round_saturate at default parameters, plus a
// CNT_WIDTH=4 instance sharing the same stimulus for the counter-limit case.
module tb_complex_round_saturate;

  logic               clk = 1'b0;
  logic               rst = 1'b0;
  logic signed [32:0] i_real = '0;
  logic signed [32:0] i_imag = '0;
  logic               i_valid = 1'b0;
  logic               i_ready = 1'b1;
  logic               i_clear_sat = 1'b0;
  logic               o_ready;
  logic signed [15:0] o_real;
  logic signed [15:0] o_imag;
  logic               o_valid;
  logic               o_sat_real;
  logic               o_sat_imag;
  logic [15:0]        o_sat_count;
  logic               o4_ready;
  logic signed [15:0] o4_real;
  logic signed [15:0] o4_imag;
  logic               o4_valid;
  logic               o4_sat_real;
  logic               o4_sat_imag;
  logic [3:0]         o4_sat_count;

  complex_round_saturate u_dut (
    .i_clk(clk), .i_rst(rst), .i_real(i_real), .i_imag(i_imag), .i_valid(i_valid),
    .o_ready(o_ready), .o_real(o_real), .o_imag(o_imag), .o_valid(o_valid),
    .i_ready(i_ready), .o_sat_real(o_sat_real), .o_sat_imag(o_sat_imag),
    .o_sat_count(o_sat_count), .i_clear_sat(i_clear_sat)
  );

  complex_round_saturate #(.CNT_WIDTH(4)) u_dut4 (
    .i_clk(clk), .i_rst(rst), .i_real(i_real), .i_imag(i_imag), .i_valid(i_valid),
    .o_ready(o4_ready), .o_real(o4_real), .o_imag(o4_imag), .o_valid(o4_valid),
    .i_ready(i_ready), .o_sat_real(o4_sat_real), .o_sat_imag(o4_sat_imag),
    .o_sat_count(o4_sat_count), .i_clear_sat(i_clear_sat)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic signed [32:0] re;
    logic signed [32:0] im;
    logic signed [15:0] ere;
    logic signed [15:0] eim;
  } vec_t;

  typedef struct {
    logic signed [15:0] re;
    logic signed [15:0] im;
  } exp_t;

  exp_t               sb[$];
  exp_t               e;
  vec_t               tbl[8];
  logic signed [15:0] cur_re = '0;
  logic signed [15:0] cur_im = '0;
  int                 n_cmp = 0;
  int                 n_fail = 0;
  int                 rdy_mode = 0;
  bit                 lat_chk = 1'b0;
  bit                 acc_d1 = 1'b0;
  bit                 acc_d2 = 1'b0;

  function automatic void check(input string name, input longint act, input longint exp);
    n_cmp++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d at %0t", name, act, exp, $time);
    end
  endfunction

  // Reference: exact real-valued division, rounding and clamping.
  function automatic logic signed [15:0] model(input logic signed [32:0] x);
    real    v;
    real    fl;
    real    fr;
    longint q;
    v  = x;
    v  = v / 32768.0;
    fl = $floor(v);
    fr = v - fl;
    q  = longint'(fl);
    if (fr > 0.5) q++;
    else if (fr == 0.5) begin
`ifdef ROUND_EVEN_EN
      if (q % 2 != 0) q++;
`else
      q++;
`endif
    end
    if (q > 32767) q = 32767;
    if (q < -32768) q = -32768;
    return 16'(q);
  endfunction

  // Scoreboard / monitor, sampled on the falling edge.
  always @(negedge clk) begin
    if (!rst) begin
      check("o_ready", o_ready, !(sb.size() == 2 && !i_ready));
      if (lat_chk) check("valid_latency", o_valid, acc_d2);
      if (o_valid && i_ready) begin
        if (sb.size() == 0) begin
          n_cmp++;
          n_fail++;
          $display("FAIL unexpected_output: got o_real %0d, expected no output", o_real);
        end else begin
          e = sb.pop_front();
          check("o_real", o_real, e.re);
          check("o_imag", o_imag, e.im);
        end
      end
      if (i_valid && o_ready) sb.push_back('{cur_re, cur_im});
      acc_d2 <= acc_d1;
      acc_d1 <= i_valid && o_ready;
    end
  end

  task automatic set_ready();
    case (rdy_mode)
      0: i_ready = 1'b1;
      1: i_ready = 1'($urandom % 2);
      default: i_ready = 1'b0;
    endcase
  endtask

  task automatic idle(input int n);
    for (int k = 0; k < n; k++) begin
      @(posedge clk); #1;
      set_ready();
    end
  endtask

  task automatic send(input logic signed [32:0] re, input logic signed [32:0] im,
                      input logic signed [15:0] ere, input logic signed [15:0] eim);
    bit acc;
    int n;
    i_real = re; i_imag = im; cur_re = ere; cur_im = eim; i_valid = 1'b1;
    acc = 1'b0; n = 0;
    while (!acc && n < 200) begin
      @(negedge clk); acc = o_ready;
      @(posedge clk); #1; n++;
      set_ready();
    end
    if (!acc) check("accept_timeout", 0, 1);
    i_valid = 1'b0;
  endtask

  task automatic rand_send(input bit big);
    logic [63:0]        w;
    logic signed [31:0] t;
    logic signed [32:0] re;
    logic signed [32:0] im;
    w = {$urandom, $urandom};
    if (big) begin
      re = w[32:0]; im = w[63:31];
    end else begin
      t = w[31:0]; re = t >>> 1;
      t = w[63:32]; im = t >>> 1;
    end
    send(re, im, model(re), model(im));
  endtask

  task automatic drain();
    int n;
    rdy_mode = 0; i_ready = 1'b1; n = 0;
    while (sb.size() != 0 && n < 50) begin
      idle(1); n++;
    end
    check("drain", sb.size(), 0);
    idle(2);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    tbl[0] = '{33'sd16384, 33'sd0, 16'sd1, 16'sd0};
    tbl[1] = '{33'sd49152, 33'sd0, 16'sd2, 16'sd0};
    tbl[2] = '{-33'sd16384, 33'sd0, 16'sd0, 16'sd0};
    tbl[3] = '{-33'sd49152, 33'sd0, -16'sd1, 16'sd0};
`ifdef ROUND_EVEN_EN
    tbl[0].ere = 16'sd0;
    tbl[3].ere = -16'sd2;
`endif
    tbl[4] = '{33'sd1073741824, 33'sd0, 16'sd32767, 16'sd0};
    tbl[5] = '{33'sd0, 33'sd0, 16'sd0, -16'sd32768};
    tbl[5].im = {1'b1, 32'd0};
    tbl[6] = '{33'sd1073709056, -33'sd1073741824, 16'sd32767, -16'sd32768};
    tbl[7] = '{33'sd16383, -33'sd16385, 16'sd0, -16'sd1};

    // Reset state
    #1 rst = 1'b1;
    #2;
    check("rst_o_valid", o_valid, 0);
    check("rst_o_real", o_real, 0);
    check("rst_o_imag", o_imag, 0);
    check("rst_sat_real", o_sat_real, 0);
    check("rst_sat_imag", o_sat_imag, 0);
    check("rst_sat_count", o_sat_count, 0);
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check("rst_o_ready", o_ready, 1);
    @(posedge clk); #1;

    // Rounding and saturation vectors
    for (int i = 0; i < 8; i++) send(tbl[i].re, tbl[i].im, tbl[i].ere, tbl[i].eim);
    drain();
    check("sat_real_set", o_sat_real, 1);
    check("sat_imag_set", o_sat_imag, 1);
    check("sat_count_2", o_sat_count, 2);

    // Clear pulse
    i_clear_sat = 1'b1;
    @(posedge clk); #1 i_clear_sat = 1'b0;
    check("clr_sat_real", o_sat_real, 0);
    check("clr_sat_imag", o_sat_imag, 0);
    check("clr_sat_count", o_sat_count, 0);

    // Back-to-back streaming with latency tracking
    lat_chk = 1'b1;
    for (int i = 0; i < 100; i++) rand_send(i[0]);
    idle(3);
    lat_chk = 1'b0;
    drain();

    // Random backpressure
    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      if ($urandom % 4 == 0) idle(1);
      rand_send(i[1]);
    end
    drain();

    // Fill both stages under stall, then reset asynchronously mid-cycle
    rdy_mode = 2; i_ready = 1'b0;
    send(33'sd1073741824, 33'sd0, 16'sd32767, 16'sd0);
    send(33'sd1073741824, 33'sd0, 16'sd32767, 16'sd0);
    @(negedge clk);
    check("full_o_ready", o_ready, 0);
    check("full_o_valid", o_valid, 1);
    check("full_sat_real", o_sat_real, 1);
    #2 rst = 1'b1;
    #1;
    check("midrst_o_valid", o_valid, 0);
    check("midrst_sat_real", o_sat_real, 0);
    check("midrst_sat_count", o_sat_count, 0);
    sb.delete();
    @(posedge clk); @(posedge clk); #1;
    rdy_mode = 0; i_ready = 1'b1; rst = 1'b0;
    @(posedge clk); #1;

    // First sample after reset: two-register latency
    i_real = 33'sd98304; i_imag = -33'sd98304; cur_re = 16'sd3; cur_im = -16'sd3;
    i_valid = 1'b1;
    @(posedge clk); #1 i_valid = 1'b0;
    check("post_rst_lat1_valid", o_valid, 0);
    @(posedge clk); #1;
    check("post_rst_lat2_valid", o_valid, 1);
    check("post_rst_real", o_real, 3);
    check("post_rst_imag", o_imag, -3);
    drain();

    // Counter limit
    for (int i = 0; i < 20; i++)
      send(33'sd1073741824, 33'sd1073741824, 16'sd32767, 16'sd32767);
    drain();
    check("cnt4_hold", o4_sat_count, 15);
    check("cnt16_20", o_sat_count, 20);
    check("sb_empty", sb.size(), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/complex_round_saturate.md
# complex_round_saturate

Output formatting stage placed directly after the complex multiplier in the DDFS mixing path. It accepts the full-precision (2·DATA_WIDTH+1)-bit real/imaginary products, scales them by an arithmetic right shift with rounding, and saturates the results back to DATA_WIDTH bits. Results are delivered through a two-register valid/ready pipeline that supports backpressure. Saturation events are reported through sticky flags and a counter.

## Interface
- DATA_WIDTH, 16, output sample width; input width is IN_W = 2·DATA_WIDTH+1
- FRAC_SHIFT, 15, right-shift applied before saturation (Q2.30 → Q1.15 at defaults); legal range 1..2·DATA_WIDTH-1
- CNT_WIDTH, 16, width of the saturation event counter

Ports:
- i_clk  in  1  clock; all logic on rising edge
- i_rst  in  1  reset, asynchronous and active-high
- i_real  in  IN_W  signed real product
- i_imag  in  IN_W  signed imaginary product
- i_valid  in  1  input sample valid
- o_ready  out  1  stage can accept a sample this cycle
- o_real  out  DATA_WIDTH  signed rounded/saturated real
- o_imag  out  DATA_WIDTH  signed rounded/saturated imaginary
- o_valid  out  1  output sample valid
- i_ready  in  1  downstream accepts output
- o_sat_real  out  1  sticky: a real sample saturated
- o_sat_imag  out  1  sticky: an imaginary sample saturated
- o_sat_count  out  CNT_WIDTH  accepted samples with any saturation; holds at all-ones
- i_clear_sat  in  1  synchronous clear of sticky flags and counter

## Operation
- Stage S1 (round):
  - r = (x + round_const) >>> FRAC_SHIFT, computed in IN_W+1 bits so the add cannot overflow.
  - round_const = 2^(FRAC_SHIFT-1), i.e. round-half-up toward +∞.
  - Registers r_real, r_imag and s1_valid.
- Stage S2 (saturate):
  - If r > 2^(DATA_WIDTH-1)-1, output 2^(DATA_WIDTH-1)-1.
  - If r < -2^(DATA_WIDTH-1), output -2^(DATA_WIDTH-1).
  - Otherwise output the low DATA_WIDTH bits of r.
  - Registers o_real, o_imag and o_valid (S2 is the output register).
- Flow control:
  - load2 = !o_valid | i_ready.
  - load1 = !s1_valid | load2.
  - o_ready = load1.
  - A sample is accepted on i_valid & o_ready.
  - S1 loads on load1: s1_valid ← i_valid. Data registers are updated only when i_valid is high.
  - S2 loads on load2: o_valid ← s1_valid.
  - Bubbles collapse; no sample is dropped or duplicated.
- Saturation reporting:
  - Saturation is detected in S2 on load2 & s1_valid.
  - o_sat_real / o_sat_imag set on the corresponding detection and stay set until i_clear_sat.
  - o_sat_count increments by 1 per sample with either component saturated; it does not wrap.
  - If i_clear_sat and a detection occur in the same cycle, clear wins and that event is not recorded.
- While o_valid & !i_ready, o_real, o_imag and o_valid hold stable.

## Timing
- Reset (asynchronous assert): s1_valid=0, o_valid=0, o_real=0, o_imag=0, r_real=0, r_imag=0, o_sat_real=0, o_sat_imag=0, o_sat_count=0. o_ready=1 in the first cycle after reset.
- Reset mid-stream discards all in-flight samples. Reset release is synchronised by the integrator.
- Latency with i_ready held high: 2 cycles. A sample accepted at edge N appears with o_valid=1 after edge N+2.
- Throughput: 1 sample/cycle while i_ready=1.
- Backpressure: with i_ready=0 and o_valid=1, the block absorbs at most one further sample (into S1). o_ready then drops combinationally. Inputs must remain meaningful only while i_valid is high.
- o_ready depends combinationally on i_ready. There is no combinational path from i_valid to any output.

## Configuration
- Macro ROUND_EVEN_EN.
- Defined: convergent rounding (round-half-to-even). When the dropped FRAC_SHIFT bits equal exactly 2^(FRAC_SHIFT-1), the quotient rounds to the nearest even value. All other cases match round-half-up.
- Undefined: round-half-up as described in Operation.
- Saturation and handshake behaviour are identical in both builds.

## Test plan
All values below use the defaults (DATA_WIDTH=16, FRAC_SHIFT=15).
- Rounding, half-up build: i_real = 16384, 49152, -16384, -49152 → o_real = 1, 2, 0, -1. The ROUND_EVEN_EN build gives 0, 2, 0, -2.
- Saturation:
  - i_real = 2^30 → o_real = 32767 and o_sat_real=1.
  - i_imag = -2^32 → o_imag = -32768 and o_sat_imag=1.
  - Two such samples → o_sat_count=2.
  - Pulsing i_clear_sat → all three cleared next cycle.
- Streaming: 100 back-to-back random samples with i_ready=1 → o_valid follows i_valid delayed by 2 cycles. Outputs match the reference model bit-exactly.
- Backpressure: stream with i_ready randomly toggled at 50% → no loss, no duplication, order preserved. o_ready=0 only when both S1 and S2 are full and i_ready=0.
- Reset mid-stream: assert i_rst asynchronously between edges with both stages full → o_valid=0 and flags/counter=0 immediately. The first post-reset sample emerges 2 cycles after acceptance.
- Counter limit: CNT_WIDTH=4, feed 20 saturating samples → o_sat_count holds at 15.
